// File: rtl/uart_tx_sched.sv
// uart_tx_sched: one 8N1 UART transmitter shared by two byte requesters
// using round-robin arbitration, with its own baud-rate divider.
// Optional build macro UART_TX_SCHED_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line high, arbitrating between requesters
//   START  | start bit (low) for COUNT_MAX clocks
//   DATA   | 8 data bits, LSB first, COUNT_MAX clocks each
//   PARITY | even parity of the latched byte (parity build only)
//   STOP   | stop bit (high) for COUNT_MAX clocks, then tx_done pulse
module uart_tx_sched #(
  parameter int FRE       = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid0,
  input  logic [7:0] data0,
  output logic       ready0,
  input  logic       valid1,
  input  logic [7:0] data1,
  output logic       ready1,
  output logic       tx,
  output logic       busy,
  output logic       gnt_id,
  output logic       tx_done
);

  localparam int COUNT_MAX = FRE / BAUD_RATE;
  localparam int CNT_W     = $clog2(COUNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

`ifdef UART_TX_SCHED_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rr_q, rr_d;
  logic             gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             boundary;
`ifdef UART_TX_SCHED_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The requester that is not the last winner takes priority on a tie.
  assign ready0 = (state_q == S_IDLE) && valid0 && (!valid1 || rr_q);
  assign ready1 = (state_q == S_IDLE) && valid1 && (!valid0 || !rr_q);

  assign boundary = (cnt_q == CNT_LAST);

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign gnt_id  = gnt_q;
  assign tx_done = done_q;

  // Next-state logic: arbitration, divider, frame sequencing and line level.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_SCHED_PARITY_EN
    parity_d  = parity_q;
`endif

    // Divider is held at zero in IDLE so each frame starts on a full bit.
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (boundary) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (ready0 || ready1) begin
          shift_d = ready0 ? data0 : data1;
          gnt_d   = ready1;
          rr_d    = ready1;
          busy_d  = 1'b1;
          state_d = S_START;
`ifdef UART_TX_SCHED_PARITY_EN
          parity_d = ready0 ? ^data0 : ^data1;
`endif
        end
      end
      S_START: begin
        if (boundary) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (boundary) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_SCHED_PARITY_EN
      S_PARITY: begin
        if (boundary) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (boundary) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next state so it lines up with the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_SCHED_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      rr_q      <= 1'b1;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Single UART 8N1 transmitter shared by two byte requesters, with round-robin arbitration.
- Contains its own baud-rate divider. It sequences the divider (restarts it at frame start, holds it idle otherwise) and the bit-serial frame.
- Sits between two on-chip byte producers (e.g. command path and debug/log path) and the off-chip TX pin.

Parameters:
- FRE, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- COUNT_MAX, FRE/BAUD_RATE, clocks per bit (derived; not overridden independently).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- valid0  input  1  requester 0 has a byte to send.
- data0  input  8  requester 0 byte; must be stable while valid0=1.
- ready0  output  1  requester 0 byte accepted this cycle.
- valid1  input  1  requester 1 has a byte to send.
- data1  input  8  requester 1 byte.
- ready1  output  1  requester 1 byte accepted this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- gnt_id  output  1  requester index of the frame in flight/last sent.
- tx_done  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset (async assert, sync deassert use): tx=1, busy=0, gnt_id=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, rr pointer=1 (so requester 0 wins first).
- ready0/ready1 are combinational. Only in IDLE, at most one high:
  - both valid: grant the index != rr pointer.
  - one valid: grant it.
- Handshake: a transfer occurs on the rising edge where valid_i && ready_i. On that edge:
  - data_i is latched into the shift register.
  - gnt_id <= i, rr pointer <= i.
  - busy <= 1, baud counter <= 0, state <= START.
- Requesters may drop valid without a transfer; no data is lost or duplicated.
- Baud counter counts 0..COUNT_MAX-1 only when state != IDLE. A bit boundary occurs when counter == COUNT_MAX-1; the counter then wraps to 0. Counter width is sufficient for COUNT_MAX-1 (derived from the parameter, not fixed).
- FSM (tx registered, driven from state):
  - IDLE: tx=1. Transition on handshake.
  - START: tx=0 for COUNT_MAX clocks, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. At each boundary, shift right and increment the index. After bit 7's boundary go to STOP (or PARITY, see option).
  - STOP: tx=1 for COUNT_MAX clocks. At the boundary: state <= IDLE, busy <= 0, tx_done=1 for exactly one cycle.
- Latency: tx falls 1 clock after the handshake edge. Frame length is 10*COUNT_MAX clocks. The minimum gap between frames is 1 IDLE clock (arbitration cycle). gnt_id holds its value after the frame until the next grant.
- Simultaneous valid0 and valid1 held continuously: frames strictly alternate 0,1,0,1...
- A new valid arriving during a frame waits; ready stays 0 until IDLE.
- Reset asserted mid-frame: tx returns to 1 immediately (async). No tx_done. The byte is dropped; the requester already saw its ready.
- COUNT_MAX must be >= 2; smaller values are unsupported.

Optional Feature:
- Macro UART_TX_SCHED_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits, computed at latch time) for COUNT_MAX clocks.
  - Frame = 11*COUNT_MAX clocks.
- Undefined: no PARITY state or parity logic; 8N1 only.

Test Plan (FRE=1000, BAUD_RATE=100, COUNT_MAX=10):
- Reset low 3 clks then high, no valids -> tx=1, busy=0, ready0=ready1=0, gnt_id=0, tx_done=0 for 200 clks.
- valid0=1, data0=0xA5 for one handshake -> ready0=1 that cycle. tx: 0 for 10 clks, then bits 1,0,1,0,0,1,0,1 (10 clks each), then 1 for 10 clks. tx_done pulses at clk 100 after the handshake. gnt_id=0.
- valid0 and valid1 both held high, data0=0x00, data1=0xFF -> grant order 0,1,0,1. 101 clks between successive handshakes. gnt_id toggles each frame.
- valid1 asserted at clk 30 of a requester-0 frame -> ready1 stays 0 until the IDLE cycle after tx_done, then ready1=1 for one cycle.
- Reset driven low at clk 45 of a frame -> tx=1 and busy=0 in the same cycle. After release, valid0+valid1 -> requester 0 granted first.
- With UART_TX_SCHED_PARITY_EN, data0=0x07 -> parity bit tx=1 for 10 clks after bit 7, stop follows, tx_done at clk 110. With data0=0x03 the parity bit is 0.
